// File: rtl/npc_pkg.sv
// npc_pkg: shared pipeline constants, including the default payload widths of the D/X/M/W stage buses
package npc_pkg;
   localparam int D_WIDTH = 32;
   localparam int X_WIDTH = 32;
   localparam int M_WIDTH = 32;
   localparam int W_WIDTH = 32;
   typedef enum logic [1:0] {STG_D, STG_X, STG_M, STG_W} stage_e;
   function automatic int stage_width(stage_e s);
      return s == STG_D ? D_WIDTH : s == STG_X ? X_WIDTH : s == STG_M ? M_WIDTH : W_WIDTH;
   endfunction
endpackage

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: valid/ready upstream and downstream buses plus flush and occupancy of a stage buffer
interface pipe_stage_buf_if import npc_pkg::*; #(
   parameter int WIDTH = X_WIDTH,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH + 1);
   logic             flush;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic [CW-1:0]    count;
   modport master (output flush, s_valid, s_data, m_ready, input s_ready, m_valid, m_data, count);
   modport slave (input flush, s_valid, s_data, m_ready, output s_ready, m_valid, m_data, count);
endinterface

// File: rtl/ring_ptr.sv
// ring_ptr: circular index that wraps from DEPTH-1 back to 0, clearable by a redirect
module ring_ptr #(
   parameter int DEPTH = 2,
   parameter int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [PW-1:0] ptr
);
   logic [PW-1:0] ptr_q, ptr_d;
   // next index: clear wins, otherwise advance with wrap
   always_comb ptr_d = clr ? '0 : !inc ? ptr_q : ptr_q == PW'(DEPTH - 1) ? '0 : ptr_q + 1'b1;
   // index register
   always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
   assign ptr = ptr_q;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: circular FIFO skid buffer between pipeline stages with flush and optional empty bypass
module pipe_stage_buf import npc_pkg::*; #(
   parameter int WIDTH = X_WIDTH,
   parameter int DEPTH = 2,
   parameter int BYPASS = 0
) (
   input logic              clk,
   input logic              rst,
   pipe_stage_buf_if.slave  bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam bit BP = BYPASS != 0;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             empty, pass, push, pop, store, deq;
   // handshake decode; s_ready looks only at registered occupancy, never at m_ready
   always_comb begin
      empty = count_q == '0;
      pass = BP && empty;
      bus.s_ready = ~rst & ~bus.flush & (count_q < CW'(DEPTH));
      bus.m_valid = ~bus.flush & (pass ? bus.s_valid : ~empty);
      bus.m_data = pass ? bus.s_data : mem_q[rd_ptr];
      bus.count = count_q;
      push = bus.s_valid & bus.s_ready;
      pop = bus.m_valid & bus.m_ready;
      store = push & ~(pass & bus.m_ready);
      deq = pop & ~empty;
      count_d = bus.flush ? '0 : count_q + CW'(store) - CW'(deq);
   end
   // occupancy register
   always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
   // payload storage, intentionally not reset
   always_ff @(posedge clk) if (store) mem_q[wr_ptr] <= bus.s_data;
   ring_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr (.clk(clk), .rst(rst), .clr(bus.flush), .inc(store), .ptr(wr_ptr));
   ring_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd (.clk(clk), .rst(rst), .clr(bus.flush), .inc(deq), .ptr(rd_ptr));
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: vector table, streaming scoreboard and corner sequences for pipe_stage_buf
module tb_pipe_stage_buf;
   import npc_pkg::*;
   logic clk = 0;
   logic rst = 1;
   int total = 0;
   int passed = 0;
   always #5 clk = ~clk;

   pipe_stage_buf_if #(.WIDTH(8), .DEPTH(2)) a_if();
   pipe_stage_buf_if #(.WIDTH(8), .DEPTH(3)) b_if();
   pipe_stage_buf_if #(.WIDTH(8), .DEPTH(2)) c_if();
   pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .BYPASS(0)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
   pipe_stage_buf #(.WIDTH(8), .DEPTH(3), .BYPASS(0)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
   pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .BYPASS(1)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));

   typedef struct {
      logic       sv;
      logic [7:0] sd;
      logic       mr;
      logic       fl;
      logic       sr;
      logic       mv;
      logic [7:0] md;
      logic [1:0] cnt;
   } vec_t;
   vec_t tbl [13];
   logic [7:0] exp_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic sv, input logic [7:0] sd, input logic mr, input logic fl);
      a_if.s_valid = sv;
      a_if.s_data = sd;
      a_if.m_ready = mr;
      a_if.flush = fl;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int tx, rx;
      a_if.flush = 0; a_if.s_valid = 0; a_if.s_data = 0; a_if.m_ready = 0;
      b_if.flush = 0; b_if.s_valid = 0; b_if.s_data = 0; b_if.m_ready = 0;
      c_if.flush = 0; c_if.s_valid = 0; c_if.s_data = 0; c_if.m_ready = 0;
      // fill: push A,B then C refused; drain; then flush at count 2 with 0x55 offered
      tbl[0]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
      tbl[1]  = '{1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0A, 2'd1};
      tbl[2]  = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd2};
      tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd2};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0B, 2'd1};
      tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
      tbl[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
      tbl[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 2'd1};
      tbl[8]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd2};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
      tbl[10] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 2'd1};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};

      step();
      @(negedge clk);
      chk("rst_sready_low", 32'(a_if.s_ready), 0);
      step();
      rst = 0;
      @(negedge clk);
      chk("rst_a_count", 32'(a_if.count), 0);
      chk("rst_a_mvalid", 32'(a_if.m_valid), 0);
      chk("rst_a_sready", 32'(a_if.s_ready), 1);
      chk("rst_b_count", 32'(b_if.count), 0);
      chk("rst_c_mvalid", 32'(c_if.m_valid), 0);

      for (int i = 0; i < 13; i++) begin
         step();
         drive_a(tbl[i].sv, tbl[i].sd, tbl[i].mr, tbl[i].fl);
         @(negedge clk);
         chk($sformatf("v%0d_sready", i), 32'(a_if.s_ready), 32'(tbl[i].sr));
         chk($sformatf("v%0d_mvalid", i), 32'(a_if.m_valid), 32'(tbl[i].mv));
         chk($sformatf("v%0d_count", i), 32'(a_if.count), 32'(tbl[i].cnt));
         if (tbl[i].mv) chk($sformatf("v%0d_mdata", i), 32'(a_if.m_data), 32'(tbl[i].md));
      end

      // DEPTH=3 stream 0..9, m_ready toggling 1,0
      tx = 0;
      rx = 0;
      for (int cyc = 0; cyc < 200 && rx < 10; cyc++) begin
         step();
         b_if.s_valid = tx < 10;
         b_if.s_data = 8'(tx);
         b_if.m_ready = cyc[0] == 1'b0;
         @(negedge clk);
         if (b_if.s_valid && b_if.s_ready) begin
            exp_q.push_back(b_if.s_data);
            tx++;
         end
         if (b_if.m_valid && b_if.m_ready) begin
            chk("stream_q_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk($sformatf("stream_data%0d", rx), 32'(b_if.m_data), 32'(exp_q.pop_front()));
            rx++;
         end
      end
      chk("stream_rx_count", 32'(rx), 10);
      chk("stream_tx_count", 32'(tx), 10);
      step();
      b_if.s_valid = 0;
      b_if.m_ready = 0;
      @(negedge clk);
      chk("stream_end_count", 32'(b_if.count), 0);

      // BYPASS: pass-through when consumed, stored when stalled
      step();
      c_if.s_valid = 1; c_if.s_data = 8'h77; c_if.m_ready = 1;
      @(negedge clk);
      chk("byp_mvalid", 32'(c_if.m_valid), 1);
      chk("byp_mdata", 32'(c_if.m_data), 32'h77);
      chk("byp_count0", 32'(c_if.count), 0);
      step();
      c_if.s_valid = 0;
      @(negedge clk);
      chk("byp_next_count", 32'(c_if.count), 0);
      chk("byp_next_mvalid", 32'(c_if.m_valid), 0);
      step();
      c_if.s_valid = 1; c_if.s_data = 8'h66; c_if.m_ready = 0;
      @(negedge clk);
      chk("byp_stall_mdata", 32'(c_if.m_data), 32'h66);
      step();
      c_if.s_valid = 0; c_if.s_data = 8'hEE; c_if.m_ready = 1;
      @(negedge clk);
      chk("byp_stored_count", 32'(c_if.count), 1);
      chk("byp_stored_mvalid", 32'(c_if.m_valid), 1);
      chk("byp_stored_mdata", 32'(c_if.m_data), 32'h66);
      step();
      c_if.m_ready = 0;
      @(negedge clk);
      chk("byp_drained", 32'(c_if.count), 0);

      // reset pulse at count 2 with a push attempted during reset
      step();
      drive_a(1, 8'h11, 0, 0);
      step();
      drive_a(1, 8'h22, 0, 0);
      step();
      rst = 1;
      drive_a(1, 8'h99, 0, 0);
      @(negedge clk);
      chk("rstp_pre_count", 32'(a_if.count), 2);
      chk("rstp_sready_low", 32'(a_if.s_ready), 0);
      step();
      rst = 0;
      drive_a(1, 8'h33, 0, 0);
      @(negedge clk);
      chk("rstp_count", 32'(a_if.count), 0);
      chk("rstp_mvalid", 32'(a_if.m_valid), 0);
      chk("rstp_sready", 32'(a_if.s_ready), 1);
      step();
      drive_a(0, 8'h00, 0, 0);
      @(negedge clk);
      chk("rstp_first_mvalid", 32'(a_if.m_valid), 1);
      chk("rstp_first_mdata", 32'(a_if.m_data), 32'h33);
      chk("rstp_first_count", 32'(a_if.count), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the payload width in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of buffer entries (DEPTH >= 1; need not be a power of two).
REQ-003 The block SHALL have parameter BYPASS, default 0; a value of 1 enables empty-buffer combinational pass-through.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port flush, input, 1 bit: discards all buffered entries (pipeline redirect).
REQ-007 Port s_valid, input, 1 bit: upstream holds a valid payload.
REQ-008 Port s_ready, output, 1 bit: the buffer accepts the upstream payload this cycle.
REQ-009 Port s_data, input, WIDTH bits: upstream payload.
REQ-010 Port m_valid, output, 1 bit: the buffer presents a valid payload downstream.
REQ-011 Port m_ready, input, 1 bit: downstream accepts the payload this cycle.
REQ-012 Port m_data, output, WIDTH bits: downstream payload.
REQ-013 Port count, output, $clog2(DEPTH+1) bits: number of occupied entries.

Function
REQ-014 A push SHALL occur when s_valid & s_ready; a pop SHALL occur when m_valid & m_ready.
REQ-015 The buffer SHALL be a circular FIFO; the read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 s_ready SHALL be (count < DEPTH) & ~flush and SHALL NOT depend combinationally on m_ready.
REQ-017 With BYPASS=0, m_valid SHALL be (count != 0), m_data SHALL be the oldest entry, and push-to-m_valid latency SHALL be exactly 1 cycle.
REQ-018 With BYPASS=1 and count==0, m_valid SHALL equal s_valid & ~flush and m_data SHALL equal s_data; a payload consumed this way (m_ready=1) SHALL NOT be stored.
REQ-019 With BYPASS=1 and count==0, an s_valid payload with m_ready=0 SHALL be stored and presented next cycle.
REQ-020 While m_valid & ~m_ready, m_data and m_valid SHALL stay stable until the pop.
REQ-021 A simultaneous push and pop at 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-022 At count==DEPTH, s_ready SHALL be 0; a pop in that cycle SHALL make s_ready 1 the next cycle, with no same-cycle push.
REQ-023 count SHALL update to count + push - pop (BYPASS pass-through excluded) and SHALL never exceed DEPTH or underflow.
REQ-024 flush SHALL take priority over push and pop: next cycle count=0 and both pointers=0; m_valid SHALL be 0 during the flush cycle itself.
REQ-025 The block SHALL NOT alter payload bits; m_data SHALL equal the s_data that was pushed.

Reset
REQ-026 On rst=1 at a clock edge: count=0, pointers=0, m_valid=0, s_ready=1 in the following cycle.
REQ-027 During rst=1, s_ready SHALL be 0; a push attempted during reset SHALL be discarded.
REQ-028 Reset asserted mid-transfer SHALL drop all entries with no partial output.
REQ-029 Storage contents need not be reset; m_data SHALL be don't-care while m_valid=0.

Structure
REQ-030 The default payload widths of the stage buses (D, X, M, W) SHALL be defined as constants in the shared package npc_pkg; this block SHALL take WIDTH from them at instantiation.
REQ-031 Pointer wrap logic SHALL be a sub-module ring_ptr (parameter DEPTH; ports clk, rst, clr, inc, ptr), instantiated twice.
REQ-032 The block SHALL be synthesizable with no latches and no combinational path from m_ready to s_ready.

Verification
REQ-033 DEPTH=2, BYPASS=0, m_ready=0: push 0xA, 0xB, then present 0xC -> s_ready=0 after 2 pushes, count=2, m_data=0xA; 0xC not accepted.
REQ-034 Same bench, full, then m_ready=1 for 3 cycles -> outputs 0xA, 0xB in order; s_ready=1 one cycle after the first pop; count goes 2, 1, 0.
REQ-035 DEPTH=3: stream 0..9 with m_ready toggling 1,0 -> output 0..9 in order, no loss or duplication; pointers wrap at least twice.
REQ-036 count=2 with flush=1 and s_valid=1 (0x55) in the same cycle -> next cycle count=0, m_valid=0; 0x55 never appears.
REQ-037 BYPASS=1, empty, s_valid=1 (0x77), m_ready=1 -> same-cycle m_valid=1, m_data=0x77; next cycle count=0.
REQ-038 rst pulse with count=2 -> next cycle count=0, m_valid=0, s_ready=1; the first subsequent push is output first.
